// File: rtl/list_packer.sv
// list_packer: packs DW-bit list elements into DBW-bit AXI4-Stream beats.
// Elements fill lanes from lane 0 upward; a beat closes when the last lane
// fills or the element carries I_LAST. Closed beats wait in a small circular
// buffer so the element side keeps flowing while the stream is stalled.
module list_packer #(
    parameter int DW  = 32,
    parameter int DBW = 256,
    parameter int BS  = 2
) (
    input  logic           ACLK,
    input  logic           ARESET,
    input  logic [DW-1:0]  IN,
    input  logic           I_VALID,
    input  logic           I_LAST,
    output logic           O_READY,
    output logic [DBW-1:0] TDATA,
    output logic [DBW/8-1:0] TKEEP,
    output logic           TLAST,
    output logic           TVALID,
    input  logic           TREADY,
    output logic [3:0]     TDEST,
    output logic [7:0]     TID,
    output logic [DBW-1:0] TUSER
);

    localparam int FS  = DBW / DW;
    localparam int LW  = $clog2(FS);
    localparam int KW  = DBW / 8;
    localparam int LCW = (LW > 0) ? LW : 1;
    localparam int PW  = (BS > 1) ? $clog2(BS) : 1;
    localparam int CW  = $clog2(BS + 1);
    localparam int BPL = DW / 8;

    logic [LCW-1:0] lane_cnt;
    logic [DBW-1:0] asm_data;
    logic [DBW-1:0] beat_data;
    logic [KW-1:0]  beat_keep;

    logic [DBW-1:0] buf_data [BS];
    logic [KW-1:0]  buf_keep [BS];
    logic           buf_last [BS];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;

    logic accept;
    logic close;
    logic pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BS - 1)) ? '0 : p + 1'b1;
    endfunction

    assign O_READY = (count < CW'(BS));
    assign TVALID  = (count != '0);
    assign accept  = I_VALID & O_READY;
    assign close   = accept & (I_LAST | (lane_cnt == LCW'(FS - 1)));
    assign pop     = TVALID & TREADY;

    // Current assembly with the incoming element dropped into its lane, plus the keep mask it implies.
    always_comb begin
        beat_data = asm_data;
        beat_keep = '0;
        for (int k = 0; k < FS; k++) begin
            if (LCW'(k) == lane_cnt) beat_data[k*DW +: DW] = IN;
        end
        for (int b = 0; b < KW; b++) begin
            beat_keep[b] = ((b / BPL) <= int'(lane_cnt));
        end
    end

    // Lane counter and assembly register; both clear when a beat closes.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            lane_cnt <= '0;
            asm_data <= '0;
        end else if (accept) begin
            if (close) begin
                lane_cnt <= '0;
                asm_data <= '0;
            end else begin
                lane_cnt <= lane_cnt + 1'b1;
                asm_data <= beat_data;
            end
        end
    end

    // Beat storage; entries are only meaningful while counted, so no reset is needed.
    always_ff @(posedge ACLK) begin
        if (close) begin
            buf_data[wr_ptr] <= beat_data;
            buf_keep[wr_ptr] <= beat_keep;
            buf_last[wr_ptr] <= I_LAST;
        end
    end

    // Circular-buffer pointers and occupancy; push and pop in one cycle leave count unchanged.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (close) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)   rd_ptr <= ptr_inc(rd_ptr);
            case ({close, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign TDATA = TVALID ? buf_data[rd_ptr] : '0;
    assign TKEEP = TVALID ? buf_keep[rd_ptr] : '0;
    assign TLAST = TVALID ? buf_last[rd_ptr] : 1'b0;
    assign TDEST = '0;
    assign TID   = '0;
    assign TUSER = '0;

endmodule

// File: tb/tb_list_packer.sv
// Directed bench for list_packer with default parameters (8 x 32-bit lanes).
module tb_list_packer;

    logic         ACLK;
    logic         ARESET;
    logic [31:0]  IN;
    logic         I_VALID;
    logic         I_LAST;
    logic         O_READY;
    logic [255:0] TDATA;
    logic [31:0]  TKEEP;
    logic         TLAST;
    logic         TVALID;
    logic         TREADY;
    logic [3:0]   TDEST;
    logic [7:0]   TID;
    logic [255:0] TUSER;

    list_packer #(.DW(32), .DBW(256), .BS(2)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .IN(IN), .I_VALID(I_VALID), .I_LAST(I_LAST),
        .O_READY(O_READY), .TDATA(TDATA), .TKEEP(TKEEP), .TLAST(TLAST),
        .TVALID(TVALID), .TREADY(TREADY), .TDEST(TDEST), .TID(TID), .TUSER(TUSER)
    );

    typedef struct {
        logic [255:0] data;
        logic [31:0]  keep;
        logic         last;
    } beat_t;

    beat_t q[$];
    int n_checks = 0;
    int n_pass   = 0;

    initial begin
        ACLK = 0;
        forever #5 ACLK = ~ACLK;
    end

    // Record every beat handed off, sampled mid-cycle.
    always @(negedge ACLK) begin
        if (!ARESET && TVALID && TREADY) q.push_back('{TDATA, TKEEP, TLAST});
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [255:0] lanes(input logic [31:0] first, input int n);
        logic [255:0] r = '0;
        for (int k = 0; k < n; k++) r[k*32 +: 32] = first + 32'(k);
        return r;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge ACLK);
            #1;
        end
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the element.
    task automatic send(input logic [31:0] d, input logic last);
        int t = 0;
        IN = d;
        I_VALID = 1'b1;
        I_LAST = last;
        @(negedge ACLK);
        while (!O_READY && t < 200) begin
            @(negedge ACLK);
            t++;
        end
        chk("send ready", O_READY, 1);
        @(posedge ACLK);
        #1;
        I_VALID = 1'b0;
        I_LAST = 1'b0;
    endtask

    task automatic chk_beat(input string tag, input int idx, input logic [255:0] d,
                            input logic [31:0] k, input logic l);
        chk({tag, " present"}, q.size() > idx, 1);
        if (q.size() > idx) begin
            chk({tag, " tdata"}, q[idx].data, d);
            chk({tag, " tkeep"}, q[idx].keep, k);
            chk({tag, " tlast"}, q[idx].last, l);
        end
    endtask

    initial begin
        ARESET = 1'b1;
        IN = '0;
        I_VALID = 1'b0;
        I_LAST = 1'b0;
        TREADY = 1'b1;
        idle(2);
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("rst tvalid", TVALID, 0);
        chk("rst tlast", TLAST, 0);
        chk("rst tkeep", TKEEP, 0);
        chk("rst tdata", TDATA, 0);
        chk("rst o_ready", O_READY, 1);
        @(posedge ACLK);
        #1;

        // Full beat, I_LAST on lane 7, one-cycle latency, no trailing empty beat
        for (int i = 1; i <= 8; i++) begin
            if (i == 8) chk("full tvalid before close", TVALID, 0);
            send(32'(i), i == 8);
        end
        chk("full tvalid after close", TVALID, 1);
        idle(4);
        chk("full beat count", q.size(), 1);
        chk_beat("full", 0, lanes(32'h1, 8), 32'hFFFF_FFFF, 1);
        q.delete();

        // I_LAST on first lane
        send(32'h77, 1);
        idle(3);
        chk("single beat count", q.size(), 1);
        chk_beat("single", 0, lanes(32'h77, 1), 32'h0000_000F, 1);
        q.delete();

        // Partial beat of three
        send(32'hA, 0);
        send(32'hB, 0);
        send(32'hC, 1);
        idle(3);
        chk("partial beat count", q.size(), 1);
        chk_beat("partial", 0, lanes(32'hA, 3), 32'h0000_0FFF, 1);
        q.delete();

        // Twenty-element list across three beats
        for (int i = 1; i <= 20; i++) send(32'(i), i == 20);
        idle(4);
        chk("multi beat count", q.size(), 3);
        chk_beat("multi0", 0, lanes(32'd1, 8), 32'hFFFF_FFFF, 0);
        chk_beat("multi1", 1, lanes(32'd9, 8), 32'hFFFF_FFFF, 0);
        chk_beat("multi2", 2, lanes(32'd17, 4), 32'h0000_FFFF, 1);
        q.delete();

        // Backpressure: 16 accepted, buffer full, head stable
        TREADY = 1'b0;
        for (int i = 1; i <= 16; i++) send(32'h300 + 32'(i), 0);
        @(negedge ACLK);
        chk("bp o_ready full", O_READY, 0);
        chk("bp tvalid", TVALID, 1);
        chk("bp head", TDATA, lanes(32'h301, 8));
        IN = 32'h311;
        I_VALID = 1'b1;
        repeat (5) @(negedge ACLK);
        chk("bp o_ready held", O_READY, 0);
        chk("bp head stable", TDATA, lanes(32'h301, 8));
        chk("bp tlast stable", TLAST, 0);
        chk("bp nothing out", q.size(), 0);
        @(posedge ACLK);
        #1;
        TREADY = 1'b1;
        for (int i = 17; i <= 24; i++) send(32'h300 + 32'(i), i == 24);
        idle(5);
        chk("bp beat count", q.size(), 3);
        chk_beat("bp0", 0, lanes(32'h301, 8), 32'hFFFF_FFFF, 0);
        chk_beat("bp1", 1, lanes(32'h309, 8), 32'hFFFF_FFFF, 0);
        chk_beat("bp2", 2, lanes(32'h311, 8), 32'hFFFF_FFFF, 1);
        q.delete();

        // Toggling TREADY with continuous input
        fork
            begin
                repeat (40) begin
                    @(posedge ACLK);
                    #1;
                    TREADY = ~TREADY;
                end
            end
            begin
                for (int i = 0; i < 16; i++) send(32'h200 + 32'(i), i == 15);
            end
        join
        TREADY = 1'b1;
        idle(5);
        chk("toggle beat count", q.size(), 2);
        chk_beat("toggle0", 0, lanes(32'h200, 8), 32'hFFFF_FFFF, 0);
        chk_beat("toggle1", 1, lanes(32'h208, 8), 32'hFFFF_FFFF, 1);
        q.delete();

        // Reset with one buffered beat and a partial assembly
        TREADY = 1'b0;
        for (int i = 0; i < 8; i++) send(32'h400 + 32'(i), i == 7);
        for (int i = 0; i < 5; i++) send(32'h410 + 32'(i), 0);
        chk("prerst tvalid", TVALID, 1);
        ARESET = 1'b1;
        idle(1);
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("midrst tvalid", TVALID, 0);
        chk("midrst o_ready", O_READY, 1);
        chk("midrst tkeep", TKEEP, 0);
        q.delete();
        @(posedge ACLK);
        #1;
        TREADY = 1'b1;
        for (int i = 0; i < 8; i++) send(32'h100 + 32'(i), i == 7);
        idle(5);
        chk("postrst beat count", q.size(), 1);
        chk_beat("postrst", 0, lanes(32'h100, 8), 32'hFFFF_FFFF, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
